// File: rtl/bypass_select_controller.sv
// Multi-stage bypass select controller for the register-read/execute boundary.
// Tracks destination physical registers issued by NUM_LANES lanes over the last
// BYPASS_DEPTH advancing cycles and produces a registered per-operand bypass
// select (hit / producer stage / producer lane) for use in execute.
// Optional feature macro: RSD_BYPASS_HIT_COUNTER_EN adds the 32-bit hitCount
// output counting bypass hits.

// Per-lane match/priority logic for all source operands of one RR lane.
module bypass_select_lane #(
  parameter int NUM_LANES      = 4,
  parameter int NUM_SRC        = 2,
  parameter int BYPASS_DEPTH   = 2,
  parameter int PREG_NUM_WIDTH = 7,
  parameter int LW             = 2,
  parameter int SW             = 1
) (
  input  logic                                                   valid_i,
  input  logic [NUM_SRC-1:0]                                     read_src_i,
  input  logic [NUM_SRC-1:0][PREG_NUM_WIDTH-1:0]                 src_reg_i,
  input  logic [BYPASS_DEPTH-1:0][NUM_LANES-1:0]                 hist_vld_i,
  input  logic [BYPASS_DEPTH-1:0][NUM_LANES-1:0][PREG_NUM_WIDTH-1:0] hist_dst_i,
  output logic [NUM_SRC-1:0]                                     hit_o,
  output logic [NUM_SRC-1:0][SW-1:0]                             stage_o,
  output logic [NUM_SRC-1:0][LW-1:0]                             lane_o
);

  // Scan oldest->youngest, highest->lowest lane so the last match written is
  // the youngest stage and, within it, the lowest lane.
  always_comb begin
    hit_o   = '0;
    stage_o = '0;
    lane_o  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = BYPASS_DEPTH - 1; k >= 0; k--) begin
        for (int m = NUM_LANES - 1; m >= 0; m--) begin
          if (valid_i && read_src_i[s] && hist_vld_i[k][m] &&
              (hist_dst_i[k][m] == src_reg_i[s])) begin
            hit_o[s]   = 1'b1;
            stage_o[s] = SW'(k);
            lane_o[s]  = LW'(m);
          end
        end
      end
    end
  end

endmodule

module bypass_select_controller #(
  parameter int NUM_LANES      = 4,
  parameter int NUM_SRC        = 2,
  parameter int BYPASS_DEPTH   = 2,
  parameter int PREG_NUM_WIDTH = 7,
  localparam int LW = (NUM_LANES    > 1) ? $clog2(NUM_LANES)    : 1,
  localparam int SW = (BYPASS_DEPTH > 1) ? $clog2(BYPASS_DEPTH) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              stall,
  input  logic                                              flush,
  input  logic [NUM_LANES-1:0]                              rrValid,
  input  logic [NUM_LANES-1:0]                              rrWriteReg,
  input  logic [NUM_LANES-1:0][PREG_NUM_WIDTH-1:0]          rrDstReg,
  input  logic [NUM_LANES-1:0][NUM_SRC-1:0]                 rrReadSrc,
  input  logic [NUM_LANES-1:0][NUM_SRC-1:0][PREG_NUM_WIDTH-1:0] rrSrcReg,
  output logic [NUM_LANES-1:0][NUM_SRC-1:0]                 exHit,
  output logic [NUM_LANES-1:0][NUM_SRC-1:0][SW-1:0]         exStage,
  output logic [NUM_LANES-1:0][NUM_SRC-1:0][LW-1:0]         exLane
`ifdef RSD_BYPASS_HIT_COUNTER_EN
  ,
  output logic [31:0]                                       hitCount
`endif
);

  // History index 0 is h[1] (the group one advancing cycle ahead of RR).
  logic [BYPASS_DEPTH-1:0][NUM_LANES-1:0]                     hist_vld_q;
  logic [BYPASS_DEPTH-1:0][NUM_LANES-1:0][PREG_NUM_WIDTH-1:0] hist_dst_q;

  logic [NUM_LANES-1:0][NUM_SRC-1:0]         hit_d,   hit_q;
  logic [NUM_LANES-1:0][NUM_SRC-1:0][SW-1:0] stage_d, stage_q;
  logic [NUM_LANES-1:0][NUM_SRC-1:0][LW-1:0] lane_d,  lane_q;

  logic advance;
  assign advance = !stall && !flush;

  // One select engine per RR lane; all share the same history view.
  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      bypass_select_lane #(
        .NUM_LANES      (NUM_LANES),
        .NUM_SRC        (NUM_SRC),
        .BYPASS_DEPTH   (BYPASS_DEPTH),
        .PREG_NUM_WIDTH (PREG_NUM_WIDTH),
        .LW             (LW),
        .SW             (SW)
      ) u_lane (
        .valid_i    (rrValid[gl]),
        .read_src_i (rrReadSrc[gl]),
        .src_reg_i  (rrSrcReg[gl]),
        .hist_vld_i (hist_vld_q),
        .hist_dst_i (hist_dst_q),
        .hit_o      (hit_d[gl]),
        .stage_o    (stage_d[gl]),
        .lane_o     (lane_d[gl])
      );
    end
  endgenerate

  // History shift register: capture RR group on advance, wipe valids on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q <= '0;
      hist_dst_q <= '0;
    end else if (flush) begin
      hist_vld_q <= '0;
    end else if (!stall) begin
      hist_vld_q[0] <= rrValid & rrWriteReg;
      hist_dst_q[0] <= rrDstReg;
      for (int k = 1; k < BYPASS_DEPTH; k++) begin
        hist_vld_q[k] <= hist_vld_q[k-1];
        hist_dst_q[k] <= hist_dst_q[k-1];
      end
    end
  end

  // Registered bypass select handed to the execute stage.
  always_ff @(posedge clk) begin
    if (rst || (flush)) begin
      hit_q   <= '0;
      stage_q <= '0;
      lane_q  <= '0;
    end else if (advance) begin
      hit_q   <= hit_d;
      stage_q <= stage_d;
      lane_q  <= lane_d;
    end
  end

  assign exHit   = hit_q;
  assign exStage = stage_q;
  assign exLane  = lane_q;

`ifdef RSD_BYPASS_HIT_COUNTER_EN
  logic [31:0] hit_cnt_q;

  // Accumulate operands that hit this advancing cycle; wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (advance) begin
      hit_cnt_q <= hit_cnt_q + 32'($countones(hit_d));
    end
  end

  assign hitCount = hit_cnt_q;
`endif

endmodule

// File: tb/tb_bypass_select_controller.sv
// Directed self-checking bench for bypass_select_controller (default params:
// 4 lanes, 2 sources, depth 2, 7-bit pregs). Operand (l,s) is exHit bit l*2+s.
module tb_bypass_select_controller;

  logic clk, rst, stall, flush;
  logic [3:0]            rrValid, rrWriteReg;
  logic [3:0][6:0]       rrDstReg;
  logic [3:0][1:0]       rrReadSrc;
  logic [3:0][1:0][6:0]  rrSrcReg;
  logic [3:0][1:0]       exHit;
  logic [3:0][1:0][0:0]  exStage;
  logic [3:0][1:0][1:0]  exLane;
`ifdef RSD_BYPASS_HIT_COUNTER_EN
  logic [31:0]           hitCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bypass_select_controller dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .rrValid    (rrValid),
    .rrWriteReg (rrWriteReg),
    .rrDstReg   (rrDstReg),
    .rrReadSrc  (rrReadSrc),
    .rrSrcReg   (rrSrcReg),
    .exHit      (exHit),
    .exStage    (exStage),
    .exLane     (exLane)
`ifdef RSD_BYPASS_HIT_COUNTER_EN
    ,
    .hitCount   (hitCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_in();
    rrValid = '0; rrWriteReg = '0; rrDstReg = '0; rrReadSrc = '0; rrSrcReg = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic produce(input int l, input logic [6:0] p);
    rrValid[l] = 1'b1; rrWriteReg[l] = 1'b1; rrDstReg[l] = p;
  endtask

  task automatic consume(input int l, input int s, input logic [6:0] p);
    rrValid[l] = 1'b1; rrReadSrc[l][s] = 1'b1; rrSrcReg[l][s] = p;
  endtask

  task automatic do_reset();
    clear_in(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_in(); rst = 1'b1; stall = 1'b1; flush = 1'b1; step(); rst = 1'b0;
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL reset_hit got=%h exp=00", exHit); end
    n_checks++; if (exStage !== 8'h00) begin n_fail++; $display("FAIL reset_stage got=%h exp=00", exStage); end
    n_checks++; if (exLane !== 16'h0000) begin n_fail++; $display("FAIL reset_lane got=%h exp=0000", exLane); end
`ifdef RSD_BYPASS_HIT_COUNTER_EN
    n_checks++; if (hitCount !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", hitCount); end
`endif
    // Mid-operation reset with stall high: clears history and outputs.
    clear_in(); produce(2, 7'd17); step();
    clear_in(); consume(0, 0, 7'd17); rst = 1'b1; stall = 1'b1; step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL reset_mid_hit got=%h exp=00", exHit); end
    rst = 1'b0; stall = 1'b0; step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL reset_hist_cleared got=%h exp=00", exHit); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Same-group read of p17 must not bypass from the op writing it.
    clear_in(); produce(2, 7'd17); consume(3, 0, 7'd17); step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL b2b_same_group got=%h exp=00", exHit); end
    clear_in(); consume(0, 0, 7'd17); step();
    n_checks++; if (exHit !== 8'h01) begin n_fail++; $display("FAIL b2b_hit got=%h exp=01", exHit); end
    n_checks++; if (exStage[0][0] !== 1'b0) begin n_fail++; $display("FAIL b2b_stage got=%0d exp=0", exStage[0][0]); end
    n_checks++; if (exLane[0][0] !== 2'd2) begin n_fail++; $display("FAIL b2b_lane got=%0d exp=2", exLane[0][0]); end
  endtask

  task automatic test_age_out();
    do_reset();
    clear_in(); produce(1, 7'd5); step();
    clear_in(); step();
    clear_in(); consume(1, 1, 7'd5); step();
    n_checks++; if (exHit !== 8'h08) begin n_fail++; $display("FAIL age_hit got=%h exp=08", exHit); end
    n_checks++; if (exStage[1][1] !== 1'b1) begin n_fail++; $display("FAIL age_stage got=%0d exp=1", exStage[1][1]); end
    n_checks++; if (exLane[1][1] !== 2'd1) begin n_fail++; $display("FAIL age_lane got=%0d exp=1", exLane[1][1]); end
    clear_in(); consume(1, 1, 7'd5); step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL age_drop got=%h exp=00", exHit); end
  endtask

  task automatic test_priority();
    do_reset();
    clear_in(); produce(3, 7'd9); step();
    clear_in(); produce(0, 7'd9); step();
    clear_in(); consume(2, 0, 7'd9); step();
    n_checks++; if (exHit !== 8'h10) begin n_fail++; $display("FAIL young_hit got=%h exp=10", exHit); end
    n_checks++; if (exStage[2][0] !== 1'b0) begin n_fail++; $display("FAIL young_stage got=%0d exp=0", exStage[2][0]); end
    n_checks++; if (exLane[2][0] !== 2'd0) begin n_fail++; $display("FAIL young_lane got=%0d exp=0", exLane[2][0]); end
    // Two lanes of one stage write p40: lowest lane wins. p104 differs only in MSB.
    clear_in(); produce(1, 7'd40); produce(3, 7'd40); step();
    clear_in(); step();
    clear_in(); consume(3, 1, 7'd40); consume(0, 0, 7'd104); step();
    n_checks++; if (exHit !== 8'h80) begin n_fail++; $display("FAIL lowlane_hit got=%h exp=80", exHit); end
    n_checks++; if (exStage[3][1] !== 1'b1) begin n_fail++; $display("FAIL lowlane_stage got=%0d exp=1", exStage[3][1]); end
    n_checks++; if (exLane[3][1] !== 2'd1) begin n_fail++; $display("FAIL lowlane_lane got=%0d exp=1", exLane[3][1]); end
  endtask

  task automatic test_stall();
    do_reset();
    clear_in(); produce(2, 7'd3); step();
    clear_in(); produce(0, 7'd30); consume(1, 0, 7'd3); step();
    n_checks++; if (exHit !== 8'h04) begin n_fail++; $display("FAIL stall_pre_hit got=%h exp=04", exHit); end
    for (int c = 1; c <= 3; c++) begin
      clear_in(); stall = 1'b1; produce(1, 7'd99); consume(3, 1, 7'd30); step();
      n_checks++; if (exHit !== 8'h04) begin n_fail++; $display("FAIL stall_hold_hit c=%0d got=%h exp=04", c, exHit); end
      n_checks++; if (exLane[1][0] !== 2'd2) begin n_fail++; $display("FAIL stall_hold_lane c=%0d got=%0d exp=2", c, exLane[1][0]); end
    end
    clear_in(); consume(2, 1, 7'd30); consume(0, 0, 7'd99); step();
    n_checks++; if (exHit !== 8'h20) begin n_fail++; $display("FAIL stall_after_hit got=%h exp=20", exHit); end
    n_checks++; if (exStage[2][1] !== 1'b0) begin n_fail++; $display("FAIL stall_after_stage got=%0d exp=0", exStage[2][1]); end
    n_checks++; if (exLane[2][1] !== 2'd0) begin n_fail++; $display("FAIL stall_after_lane got=%0d exp=0", exLane[2][1]); end
  endtask

  task automatic test_flush();
    do_reset();
    clear_in(); produce(1, 7'd20); step();
    clear_in(); produce(3, 7'd12); consume(0, 0, 7'd20); step();
    n_checks++; if (exHit !== 8'h01 || exLane[0][0] !== 2'd1) begin
      n_fail++; $display("FAIL flush_pre got=%h/%0d exp=01/1", exHit, exLane[0][0]); end
    clear_in(); flush = 1'b1; produce(0, 7'd44); consume(2, 0, 7'd12); step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL flush_hit got=%h exp=00", exHit); end
    n_checks++; if (exStage !== 8'h00 || exLane !== 16'h0000) begin
      n_fail++; $display("FAIL flush_sel got=%h/%h exp=00/0000", exStage, exLane); end
    clear_in(); consume(2, 0, 7'd12); consume(1, 1, 7'd44); step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL flush_dropped got=%h exp=00", exHit); end
    // Flush beats stall.
    clear_in(); produce(0, 7'd50); step();
    clear_in(); consume(3, 0, 7'd50); step();
    clear_in(); flush = 1'b1; stall = 1'b1; step();
    n_checks++; if (exHit !== 8'h00) begin n_fail++; $display("FAIL flush_over_stall got=%h exp=00", exHit); end
  endtask

`ifdef RSD_BYPASS_HIT_COUNTER_EN
  task automatic test_counter();
    do_reset();
    clear_in(); produce(0, 7'd1); step();
    for (int c = 0; c < 4; c++) begin
      clear_in(); produce(0, 7'd1); consume(1, 0, 7'd1); consume(2, 0, 7'd1); consume(3, 0, 7'd1); step();
    end
    n_checks++; if (hitCount !== 32'd12) begin n_fail++; $display("FAIL cnt_12 got=%0d exp=12", hitCount); end
    stall = 1'b1; step(); step();
    n_checks++; if (hitCount !== 32'd12) begin n_fail++; $display("FAIL cnt_stall got=%0d exp=12", hitCount); end
    stall = 1'b0; flush = 1'b1; step();
    n_checks++; if (hitCount !== 32'd12) begin n_fail++; $display("FAIL cnt_flush got=%0d exp=12", hitCount); end
    clear_in(); rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (hitCount !== 32'd0) begin n_fail++; $display("FAIL cnt_rst got=%0d exp=0", hitCount); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_back_to_back();
    test_age_out();
    test_priority();
    test_stall();
    test_flush();
`ifdef RSD_BYPASS_HIT_COUNTER_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
